// File: rtl/regfile_sequencer.sv
// Multi-cycle register file access controller: two operand reads, optional write-back.
// Define REGFILE_SEQ_ZERO_REG_EN to hard-wire register index 0 to zero.
module regfile_sequencer (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic        START,
  input  logic [4:0]  RS,
  input  logic [4:0]  RT,
  input  logic [4:0]  RD,
  input  logic        WB_EN,
  input  logic [31:0] WB_DATA,
  input  logic [31:0] RF_OUT_DATA,
  output logic [4:0]  REG_SRC0,
  output logic [4:0]  REG_SRC1,
  output logic [4:0]  REG_SRC2,
  output logic [1:0]  REG_SEL,
  output logic [31:0] RF_IN_DATA,
  output logic        RF_N_OE,
  output logic        RF_N_WE,
  output logic [31:0] OP_A,
  output logic [31:0] OP_B,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    FIN
  } state_t;

  state_t state;
  logic   wb_flag;
  logic   zero_a;
  logic   zero_b;
  logic   zero_d;

`ifdef REGFILE_SEQ_ZERO_REG_EN
  assign zero_a = (REG_SRC0 == 5'd0);
  assign zero_b = (REG_SRC1 == 5'd0);
  assign zero_d = (REG_SRC2 == 5'd0);
`else
  assign zero_a = 1'b0;
  assign zero_b = 1'b0;
  assign zero_d = 1'b0;
`endif

  // Outputs are registered: each one is set on the edge entering the state that owns it,
  // so REG_SEL and the strobes change together and never glitch within a cycle.
  always_ff @(posedge CLK) begin
    if (N_RST) begin
      state      <= IDLE;
      wb_flag    <= 1'b0;
      REG_SRC0   <= 5'd0;
      REG_SRC1   <= 5'd0;
      REG_SRC2   <= 5'd0;
      REG_SEL    <= 2'd0;
      RF_IN_DATA <= 32'd0;
      RF_N_OE    <= 1'b1;
      RF_N_WE    <= 1'b1;
      OP_A       <= 32'd0;
      OP_B       <= 32'd0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (START) begin
            REG_SRC0   <= RS;
            REG_SRC1   <= RT;
            REG_SRC2   <= RD;
            wb_flag    <= WB_EN;
            RF_IN_DATA <= WB_DATA;
            REG_SEL    <= 2'd0;
            RF_N_OE    <= 1'b0;
            BUSY       <= 1'b1;
            state      <= RD_A;
          end
        end
        RD_A: begin
          OP_A    <= zero_a ? 32'd0 : RF_OUT_DATA;
          REG_SEL <= 2'd1;
          state   <= RD_B;
        end
        RD_B: begin
          OP_B    <= zero_b ? 32'd0 : RF_OUT_DATA;
          RF_N_OE <= 1'b1;
          if (wb_flag) begin
            REG_SEL <= 2'd2;
            state   <= WR_SETUP;
          end else begin
            REG_SEL <= 2'd0;
            DONE    <= 1'b1;
            state   <= FIN;
          end
        end
        WR_SETUP: begin
          // A suppressed write to the zero register still spends the strobe cycle.
          RF_N_WE <= zero_d;
          state   <= WR_STROBE;
        end
        WR_STROBE: begin
          RF_N_WE <= 1'b1;
          state   <= WR_HOLD;
        end
        WR_HOLD: begin
          DONE  <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          DONE    <= 1'b0;
          BUSY    <= 1'b0;
          REG_SEL <= 2'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed testbench for regfile_sequencer with a behavioural one-port register file model.
// Expectations for the zero-register scenario follow REGFILE_SEQ_ZERO_REG_EN.
module tb_regfile_sequencer;

  logic        CLK;
  logic        N_RST;
  logic        START;
  logic [4:0]  RS;
  logic [4:0]  RT;
  logic [4:0]  RD;
  logic        WB_EN;
  logic [31:0] WB_DATA;
  logic [31:0] RF_OUT_DATA;
  logic [4:0]  REG_SRC0;
  logic [4:0]  REG_SRC1;
  logic [4:0]  REG_SRC2;
  logic [1:0]  REG_SEL;
  logic [31:0] RF_IN_DATA;
  logic        RF_N_OE;
  logic        RF_N_WE;
  logic [31:0] OP_A;
  logic [31:0] OP_B;
  logic        BUSY;
  logic        DONE;

  int n_assert = 0;
  int n_fail   = 0;
  int we_low_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_done = 1'b0;
  logic [31:0] rf [32];
  logic [4:0]  rf_addr;

  regfile_sequencer dut (
    .CLK(CLK), .N_RST(N_RST), .START(START), .RS(RS), .RT(RT), .RD(RD),
    .WB_EN(WB_EN), .WB_DATA(WB_DATA), .RF_OUT_DATA(RF_OUT_DATA),
    .REG_SRC0(REG_SRC0), .REG_SRC1(REG_SRC1), .REG_SRC2(REG_SRC2),
    .REG_SEL(REG_SEL), .RF_IN_DATA(RF_IN_DATA), .RF_N_OE(RF_N_OE),
    .RF_N_WE(RF_N_WE), .OP_A(OP_A), .OP_B(OP_B), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file model: REG_SEL picks which latched index addresses the array.
  always_comb begin
    rf_addr = REG_SRC0;
    case (REG_SEL)
      2'd1:    rf_addr = REG_SRC1;
      2'd2:    rf_addr = REG_SRC2;
      default: rf_addr = REG_SRC0;
    endcase
    RF_OUT_DATA = rf[rf_addr];
  end

  always @(posedge CLK) begin
    if (RF_N_WE === 1'b0) rf[REG_SRC2] = RF_IN_DATA;
  end

  // Mid-cycle protocol monitor: strobes never overlap and DONE is a single-cycle pulse.
  always @(negedge CLK) begin
    if (mon_en) begin
      n_assert++;
      assert ((RF_N_OE | RF_N_WE) === 1'b1) else begin
        n_fail++;
        $error("[TB] FAIL strobe_overlap: observed oe=%b we=%b expected oe|we=1", RF_N_OE, RF_N_WE);
      end
      n_assert++;
      assert (!(DONE === 1'b1 && prev_done === 1'b1)) else begin
        n_fail++;
        $error("[TB] FAIL done_pulse: observed DONE high 2 cycles expected single pulse");
      end
      if (RF_N_WE === 1'b0) we_low_cnt++;
      prev_done = DONE;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic wb_en, input logic [31:0] wb_data);
    START   = start;
    RS      = rs;
    RT      = rt;
    RD      = rd;
    WB_EN   = wb_en;
    WB_DATA = wb_data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int we_before;
    int done_seen;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    N_RST = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    tick();
    tick();
    $display("[TB] reset values");
    checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("rst_done", {31'd0, DONE}, 32'd0);
    checkOutput("rst_oe", {31'd0, RF_N_OE}, 32'd1);
    checkOutput("rst_we", {31'd0, RF_N_WE}, 32'd1);
    checkOutput("rst_sel", {30'd0, REG_SEL}, 32'd0);
    checkOutput("rst_opa", OP_A, 32'd0);
    checkOutput("rst_opb", OP_B, 32'd0);
    checkOutput("rst_src", {17'd0, REG_SRC0, REG_SRC1, REG_SRC2}, 32'd0);
    checkOutput("rst_wdata", RF_IN_DATA, 32'd0);
    N_RST  = 1'b0;
    mon_en = 1'b1;
    tick();

    $display("[TB] read-only operation");
    rf[3] = 32'h11111111;
    rf[4] = 32'h22222222;
    we_before = we_low_cnt;
    applyStimulus(1'b1, 5'd3, 5'd4, 5'd7, 1'b0, 32'hAAAA5555);
    tick();
    applyStimulus(1'b0, 5'd9, 5'd10, 5'd11, 1'b1, 32'h0);
    checkOutput("c1_sel", {30'd0, REG_SEL}, 32'd0);
    checkOutput("c1_oe", {31'd0, RF_N_OE}, 32'd0);
    checkOutput("c1_busy", {31'd0, BUSY}, 32'd1);
    tick();
    checkOutput("c2_sel", {30'd0, REG_SEL}, 32'd1);
    checkOutput("c2_opa", OP_A, 32'h11111111);
    checkOutput("c2_done", {31'd0, DONE}, 32'd0);
    tick();
    checkOutput("c3_done", {31'd0, DONE}, 32'd1);
    checkOutput("c3_opb", OP_B, 32'h22222222);
    tick();
    checkOutput("c4_done", {31'd0, DONE}, 32'd0);
    checkOutput("c4_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("ro_no_write", we_low_cnt - we_before, 32'd0);

    $display("[TB] write-back operation");
    rf[1] = 32'h01010101;
    rf[2] = 32'h02020202;
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    tick();
    checkOutput("wb_opa", OP_A, 32'h01010101);
    tick();
    checkOutput("wb_c3_sel", {30'd0, REG_SEL}, 32'd2);
    checkOutput("wb_c3_we", {31'd0, RF_N_WE}, 32'd1);
    checkOutput("wb_c3_oe", {31'd0, RF_N_OE}, 32'd1);
    checkOutput("wb_opb", OP_B, 32'h02020202);
    tick();
    checkOutput("wb_c4_we", {31'd0, RF_N_WE}, 32'd0);
    checkOutput("wb_c4_sel", {30'd0, REG_SEL}, 32'd2);
    checkOutput("wb_c4_src2", {27'd0, REG_SRC2}, 32'd5);
    checkOutput("wb_c4_wdata", RF_IN_DATA, 32'hDEADBEEF);
    tick();
    checkOutput("wb_c5_we", {31'd0, RF_N_WE}, 32'd1);
    checkOutput("wb_c5_done", {31'd0, DONE}, 32'd0);
    tick();
    checkOutput("wb_c6_done", {31'd0, DONE}, 32'd1);
    tick();
    checkOutput("wb_c7_idle", {31'd0, BUSY}, 32'd0);
    checkOutput("wb_rf5", rf[5], 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd5, 5'd3, 5'd0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    tick();
    checkOutput("readback_r5", OP_A, 32'hDEADBEEF);
    tick();
    tick();

    $display("[TB] START held continuously");
    done_seen = 0;
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 32'h00C0FFEE);
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 20) START = 1'b0;
      checkOutput($sformatf("hold_busy_%0d", k), {31'd0, BUSY}, (k % 7 == 0) ? 32'd0 : 32'd1);
      if (DONE === 1'b1) done_seen++;
    end
    checkOutput("hold_done_count", done_seen, 32'd3);
    checkOutput("hold_rf6", rf[6], 32'h00C0FFEE);

    $display("[TB] reset during write strobe");
    applyStimulus(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 32'h55667788);
    tick();
    START = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("rst_mid_strobe", {31'd0, RF_N_WE}, 32'd0);
    N_RST = 1'b1;
    tick();
    N_RST = 1'b0;
    checkOutput("rst_mid_we", {31'd0, RF_N_WE}, 32'd1);
    checkOutput("rst_mid_busy", {31'd0, BUSY}, 32'd0);
    checkOutput("rst_mid_opa", OP_A, 32'd0);
    checkOutput("rst_mid_opb", OP_B, 32'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("rst_mid_no_done", {31'd0, DONE}, 32'd0);
      tick();
    end

    $display("[TB] register zero access");
    rf[0] = 32'hFFFFFFFF;
    rf[9] = 32'h12345678;
    we_before = we_low_cnt;
    applyStimulus(1'b1, 5'd0, 5'd9, 5'd0, 1'b1, 32'hCAFEF00D);
    tick();
    START = 1'b0;
    tick();
`ifdef REGFILE_SEQ_ZERO_REG_EN
    checkOutput("zero_opa", OP_A, 32'd0);
`else
    checkOutput("zero_opa", OP_A, 32'hFFFFFFFF);
`endif
    tick();
    checkOutput("zero_opb", OP_B, 32'h12345678);
    tick();
`ifdef REGFILE_SEQ_ZERO_REG_EN
    checkOutput("zero_we", {31'd0, RF_N_WE}, 32'd1);
`else
    checkOutput("zero_we", {31'd0, RF_N_WE}, 32'd0);
`endif
    tick();
    tick();
    checkOutput("zero_done", {31'd0, DONE}, 32'd1);
    tick();
`ifdef REGFILE_SEQ_ZERO_REG_EN
    checkOutput("zero_rf0", rf[0], 32'hFFFFFFFF);
    checkOutput("zero_we_count", we_low_cnt - we_before, 32'd0);
`else
    checkOutput("zero_rf0", rf[0], 32'hCAFEF00D);
    checkOutput("zero_we_count", we_low_cnt - we_before, 32'd1);
`endif
    tick();
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Multi-cycle access controller that drives the register file's select/strobe interface: for each requested operation it reads two source registers into operand latches and optionally writes back one destination register. Sits between the instruction decode/execute logic and the register file, generating REG_SEL, N_OE and N_WE so that the one-port SRAM never sees simultaneous read and write enables. Fixed, data-independent latency, so the control unit can schedule around it.

## Interface
Parameters: none (register address width 5, data width 32, fixed).

- CLK  in  1  rising-edge clock
- N_RST  in  1  reset N_RST, synchronous, active-high
- START  in  1  request strobe; sampled only in IDLE
- RS  in  5  source A register index
- RT  in  5  source B register index
- RD  in  5  destination register index
- WB_EN  in  1  perform write-back of WB_DATA to RD
- WB_DATA  in  32  write-back data
- RF_OUT_DATA  in  32  read data from register file
- REG_SRC0  out  5  latched RS, to register file select input 0
- REG_SRC1  out  5  latched RT, to select input 1
- REG_SRC2  out  5  latched RD, to select input 2
- REG_SEL  out  2  register file mux select (0=A, 1=B, 2=D; 3 never driven)
- RF_IN_DATA  out  32  latched WB_DATA to register file
- RF_N_OE  out  1  register file output enable, active low
- RF_N_WE  out  1  register file write enable, active low
- OP_A  out  32  captured value of RS
- OP_B  out  32  captured value of RT
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RD_A, RD_B, WR_SETUP, WR_STROBE, WR_HOLD, FIN.
- IDLE: START=1 latches RS/RT/RD/WB_EN/WB_DATA into REG_SRC0/1/2, a wb flag, RF_IN_DATA; -> RD_A. START=0 stays.
- RD_A: REG_SEL=0, RF_N_OE=0; on exit edge OP_A <= RF_OUT_DATA; -> RD_B.
- RD_B: REG_SEL=1, RF_N_OE=0; on exit edge OP_B <= RF_OUT_DATA; -> WR_SETUP if wb flag else FIN.
- WR_SETUP: REG_SEL=2, RF_N_OE=1, RF_N_WE=1 (address/data settle).
- WR_STROBE: REG_SEL=2, RF_N_WE=0.
- WR_HOLD: REG_SEL=2, RF_N_WE=1, address/data held; -> FIN.
- FIN: DONE=1 for this cycle; -> IDLE.
- BUSY=1 in every state except IDLE.
- START outside IDLE ignored (not queued). Input changes after START acceptance have no effect.
- Invariant: RF_N_OE and RF_N_WE never both 0 in any cycle; REG_SEL stable for the whole cycle in which either strobe is low.
- OP_A/OP_B hold last captured values until next RD_A/RD_B capture.

## Timing
- Cycle 0: START sampled high in IDLE. Cycle 1: RD_A. Cycle 2: RD_B (OP_A valid). Cycle 3: WR_SETUP or FIN (OP_B valid).
- With write-back: FIN in cycle 6 (WR_STROBE in cycle 4); total 6 cycles from START edge to DONE. Without: FIN in cycle 3.
- Earliest next START: cycle after FIN (IDLE).
- Reset values (N_RST=1 at edge): state IDLE, REG_SEL=0, RF_N_OE=1, RF_N_WE=1, BUSY=0, DONE=0, OP_A=OP_B=0, REG_SRC0/1/2=0, RF_IN_DATA=0.
- Reset mid-operation: next edge forces IDLE and reset values; a WR_STROBE in progress is truncated (write result undefined, accepted); no DONE issued for the aborted op.
- Reset has priority over START in the same cycle.

## Configuration
- REGFILE_SEQ_ZERO_REG_EN defined: index 0 is hard-wired zero. RS=0 -> OP_A <= 0 regardless of RF_OUT_DATA; RT=0 -> OP_B <= 0; RD=0 with WB_EN -> WR_STROBE keeps RF_N_WE=1 (write suppressed). State sequence and latency unchanged.
- Not defined: index 0 is an ordinary register; all reads/writes go to the SRAM.

## Test plan
- Reset then START with RS=3, RT=4, WB_EN=0, RF model r3=0x11111111, r4=0x22222222 -> REG_SEL 0,1 in cycles 1,2; OP_A=0x11111111, OP_B=0x22222222; DONE in cycle 3; RF_N_WE never low.
- START RS=1, RT=2, RD=5, WB_EN=1, WB_DATA=0xDEADBEEF -> RF_N_WE low only in cycle 4 with REG_SEL=2, REG_SRC2=5; DONE cycle 6; subsequent read of r5 returns 0xDEADBEEF.
- START held high continuously for 20 cycles with WB_EN=1 -> operations accepted every 7 cycles, BUSY drops for exactly the IDLE cycle, no overlap.
- N_RST asserted during WR_STROBE -> next cycle RF_N_WE=1, BUSY=0, OP_A=OP_B=0, no DONE.
- With REGFILE_SEQ_ZERO_REG_EN: RS=0, RD=0, WB_EN=1, r0 model preloaded 0xFFFFFFFF -> OP_A=0, RF_N_WE stays 1, DONE still cycle 6; without macro -> OP_A=0xFFFFFFFF, write occurs.
- All scenarios: assert RF_N_OE|RF_N_WE every cycle and DONE only ever a single-cycle pulse.
